pll_lock_supervisor: RTL and testbench
======================================

# pll_lock_supervisor

Consumes the `locked` output of the system PLL and turns it into a clean, sequenced core reset. It filters and synchronizes `locked`, holds the core in reset until lock has been stable for a programmable time, and detects lock loss or lock timeout. On either event it pulses the PLL's `rst` input and retries, giving up into a sticky fault after a bounded number of attempts. It runs on the free-running board clock, never on a PLL output.

## Interface
Parameters:
- FILT_CYCLES, 4 — consecutive equal samples required before the filtered lock changes (2..15).
- STABLE_CYCLES, 1024 — filtered lock must be high this many consecutive cycles before reset release.
- LOCK_TIMEOUT, 65536 — maximum cycles in WAIT_LOCK before a timeout event.
- PLL_RST_CYCLES, 16 — width of the `pll_rst` pulse.
- RETRY_MAX, 3 — retry events tolerated before FAULT (≤3).

Ports:
- clk_sys  in  1  free-running board clock; all logic is synchronous to it.
- reset  in  1  synchronous, active-high.
- locked  in  1  PLL lock, asynchronous to clk_sys.
- pll_rst  out  1  reset request to the PLL `rst` input.
- sys_reset  out  1  core reset, active-high.
- lock_lost  out  1  one-cycle pulse on each lock-loss or timeout event.
- fault  out  1  sticky; supervisor has given up.
- retries  out  2  saturating count of retry events since reset.

## Operation
- Synchronizer: 2-FF on `locked` → `locked_s`. Filter: `locked_f` takes the value of `locked_s` once `locked_s` has held that value for FILT_CYCLES consecutive cycles. Reset value of `locked_f` is 0.
- State machine:
  - PLL_RST: `pll_rst=1` for PLL_RST_CYCLES cycles, then → WAIT_LOCK.
  - WAIT_LOCK: timeout counter runs. `locked_f=1` → STABILIZE (counter cleared). Counter reaches LOCK_TIMEOUT → retry event.
  - STABILIZE: stable counter runs while `locked_f=1`. `locked_f=0` → WAIT_LOCK; the timeout counter restarts from 0. Counter reaches STABLE_CYCLES → RUN.
  - RUN: `sys_reset=0`. `locked_f=0` → retry event.
  - FAULT: `pll_rst=0`, `sys_reset=1`, `fault=1`. Terminal until `reset`.
- Retry event:
  - `lock_lost` pulses for 1 cycle.
  - If `retries==RETRY_MAX` → FAULT.
  - Otherwise `retries` increments and the state → PLL_RST.
- `sys_reset=1` in every state except RUN. Outputs are registered.
- Reset values: `pll_rst=1` (state PLL_RST, counter 0), `sys_reset=1`, `lock_lost=0`, `fault=0`, `retries=0`.
- `reset` asserted mid-operation, in any state including FAULT, returns everything to the reset values on the next edge.
- Counters are sized by $clog2 of their parameter + 1 and never wrap: each stops at its terminal value.

## Timing
- With `locked` held high and meeting setup before edge E, `locked_f` rises at E+1+FILT_CYCLES.
- `sys_reset` falls STABLE_CYCLES+1 cycles after `locked_f` rises. Total latency from E is 2+FILT_CYCLES+STABLE_CYCLES cycles.
- `locked` glitches shorter than FILT_CYCLES cycles after synchronization have no effect.
- Lock loss in RUN: `sys_reset` rises and `lock_lost` pulses on the same edge, FILT_CYCLES+2 cycles after `locked` falls. `pll_rst` rises on that same edge.
- Timeout: `lock_lost` pulses on the edge at which WAIT_LOCK has spent LOCK_TIMEOUT cycles.

## Configuration
- PLL_SUP_AUTORETRY_EN defined: retry behaviour exactly as in Operation.
- PLL_SUP_AUTORETRY_EN undefined:
  - Any retry event goes directly to FAULT, with the `lock_lost` pulse still issued.
  - `retries` is tied to 0.
  - `pll_rst` is asserted only for the initial post-reset pulse.

## Test plan
- Reset release, `locked` raised at cycle 40 with default parameters → `pll_rst` high for cycles 0–15; `sys_reset` falls exactly 1030 cycles after the `locked` edge; `fault=0`; `retries=0`.
- In RUN, `locked` low for 3 cycles → no `lock_lost` pulse; `sys_reset` stays 0.
- In RUN, `locked` dropped and held low → single `lock_lost` pulse, `sys_reset=1` on the same cycle, 16-cycle `pll_rst` pulse, `retries=1`.
- `locked` held low throughout → `lock_lost` pulses at each timeout, `retries` 1→2→3, fourth event enters FAULT; `fault=1` and `pll_rst=0` thereafter.
- In STABILIZE at count 500, `locked` dropped for 10 cycles then restored → returns to WAIT_LOCK and the stable count restarts; release occurs a full STABLE_CYCLES after re-lock.
- `reset` asserted while in FAULT → next cycle `fault=0`, `retries=0`, `pll_rst=1`, `sys_reset=1`.

Source files
------------

// File: rtl/pll_lock_supervisor.sv
// PLL lock supervisor: sync/filter `locked`, sequence core reset, retry or fault on loss/timeout (PLL_SUP_AUTORETRY_EN enables retries).
// Latency: sys_reset releases 2+FILT_CYCLES+STABLE_CYCLES cycles after locked rises; lock loss is seen FILT_CYCLES+2 cycles after the fall.
// Backpressure: none; every output is a registered level or pulse on clk_sys.
module pll_lock_supervisor #(
  parameter int FILT_CYCLES    = 4,
  parameter int STABLE_CYCLES  = 1024,
  parameter int LOCK_TIMEOUT   = 65536,
  parameter int PLL_RST_CYCLES = 16,
  parameter int RETRY_MAX      = 3
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic       locked,
  output logic       pll_rst,
  output logic       sys_reset,
  output logic       lock_lost,
  output logic       fault,
  output logic [1:0] retries
);

  localparam int FW   = $clog2(FILT_CYCLES) + 1;
  localparam int MAXC = (LOCK_TIMEOUT > STABLE_CYCLES)
                      ? ((LOCK_TIMEOUT > PLL_RST_CYCLES) ? LOCK_TIMEOUT : PLL_RST_CYCLES)
                      : ((STABLE_CYCLES > PLL_RST_CYCLES) ? STABLE_CYCLES : PLL_RST_CYCLES);
  localparam int CW   = $clog2(MAXC) + 1;

  localparam logic [FW-1:0] FILT_LAST   = FW'(FILT_CYCLES - 1);
  localparam logic [CW-1:0] RST_LAST    = CW'(PLL_RST_CYCLES - 1);
  localparam logic [CW-1:0] STABLE_LAST = CW'(STABLE_CYCLES - 1);
  localparam logic [CW-1:0] TO_LAST     = CW'(LOCK_TIMEOUT - 1);

  typedef enum logic [2:0] {
    ST_PLL_RST,
    ST_WAIT_LOCK,
    ST_STABILIZE,
    ST_RUN,
    ST_FAULT
  } state_t;

  logic          sync_1, locked_s, locked_f;
  logic [FW-1:0] filt_cnt;
  state_t        state;
  logic [CW-1:0] cnt;
  logic          retry_ev;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      sync_1   <= 1'b0;
      locked_s <= 1'b0;
    end else begin
      sync_1   <= locked;
      locked_s <= sync_1;
    end
  end

  // locked_f only follows locked_s after FILT_CYCLES consecutive disagreeing samples
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      locked_f <= 1'b0;
      filt_cnt <= '0;
    end else if (locked_s != locked_f) begin
      if (filt_cnt == FILT_LAST) begin
        locked_f <= locked_s;
        filt_cnt <= '0;
      end else begin
        filt_cnt <= filt_cnt + 1'b1;
      end
    end else begin
      filt_cnt <= '0;
    end
  end

  // lock loss in RUN, or the last WAIT_LOCK cycle without a lock
  assign retry_ev = ((state == ST_RUN) && !locked_f) ||
                    ((state == ST_WAIT_LOCK) && !locked_f && (cnt == TO_LAST));

`ifdef PLL_SUP_AUTORETRY_EN
  localparam logic [1:0] RETRY_LIM = 2'(RETRY_MAX);
`else
  assign retries = 2'b00;
`endif

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state     <= ST_PLL_RST;
      cnt       <= '0;
      pll_rst   <= 1'b1;
      sys_reset <= 1'b1;
      lock_lost <= 1'b0;
      fault     <= 1'b0;
`ifdef PLL_SUP_AUTORETRY_EN
      retries   <= 2'b00;
`endif
    end else begin
      lock_lost <= 1'b0;
      if (retry_ev) begin
        lock_lost <= 1'b1;
        sys_reset <= 1'b1;
        cnt       <= '0;
`ifdef PLL_SUP_AUTORETRY_EN
        if (retries == RETRY_LIM) begin
          state   <= ST_FAULT;
          fault   <= 1'b1;
          pll_rst <= 1'b0;
        end else begin
          retries <= retries + 1'b1;
          state   <= ST_PLL_RST;
          pll_rst <= 1'b1;
        end
`else
        state   <= ST_FAULT;
        fault   <= 1'b1;
        pll_rst <= 1'b0;
`endif
      end else begin
        case (state)
          ST_PLL_RST: begin
            if (cnt == RST_LAST) begin
              state   <= ST_WAIT_LOCK;
              cnt     <= '0;
              pll_rst <= 1'b0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          ST_WAIT_LOCK: begin
            if (locked_f) begin
              state <= ST_STABILIZE;
              cnt   <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          ST_STABILIZE: begin
            if (!locked_f) begin
              state <= ST_WAIT_LOCK;
              cnt   <= '0;
            end else if (cnt == STABLE_LAST) begin
              state     <= ST_RUN;
              sys_reset <= 1'b0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          ST_RUN, ST_FAULT: begin
          end
          default: begin
            state     <= ST_PLL_RST;
            cnt       <= '0;
            pll_rst   <= 1'b1;
            sys_reset <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed bench for pll_lock_supervisor; LOCK_TIMEOUT shortened to 2000 to keep timeout runs short.
module tb_pll_lock_supervisor;

  logic       clk_sys;
  logic       reset;
  logic       locked;
  logic       pll_rst;
  logic       sys_reset;
  logic       lock_lost;
  logic       fault;
  logic [1:0] retries;

  int n_cmp;
  int n_bad;
  int pos;

`ifdef PLL_SUP_AUTORETRY_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  pll_lock_supervisor #(
    .FILT_CYCLES   (4),
    .STABLE_CYCLES (1024),
    .LOCK_TIMEOUT  (2000),
    .PLL_RST_CYCLES(16),
    .RETRY_MAX     (3)
  ) dut (
    .clk_sys  (clk_sys),
    .reset    (reset),
    .locked   (locked),
    .pll_rst  (pll_rst),
    .sys_reset(sys_reset),
    .lock_lost(lock_lost),
    .fault    (fault),
    .retries  (retries)
  );

  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  // pos = index of the last rising edge since reset release; sampling and driving happen at negedges
  task automatic step(input int n);
    repeat (n) @(negedge clk_sys);
    pos = pos + n;
  endtask

  task automatic goto_edge(input int p);
    step(p - pos);
  endtask

  task automatic release_reset(input logic lk);
    reset  = 1'b1;
    locked = lk;
    repeat (3) @(negedge clk_sys);
    reset = 1'b0;
    pos   = -1;
  endtask

  task automatic test_reset;
    reset  = 1'b1;
    locked = 1'b0;
    repeat (3) @(negedge clk_sys);
    n_cmp++; if (pll_rst !== 1'b1)    begin n_bad++; $display("FAIL rst_pll_rst got %b want 1", pll_rst); end
    n_cmp++; if (sys_reset !== 1'b1)  begin n_bad++; $display("FAIL rst_sys_reset got %b want 1", sys_reset); end
    n_cmp++; if (lock_lost !== 1'b0)  begin n_bad++; $display("FAIL rst_lock_lost got %b want 0", lock_lost); end
    n_cmp++; if (fault !== 1'b0)      begin n_bad++; $display("FAIL rst_fault got %b want 0", fault); end
    n_cmp++; if (retries !== 2'd0)    begin n_bad++; $display("FAIL rst_retries got %0d want 0", retries); end
    reset = 1'b0;
    pos   = -1;
    for (int i = 0; i < 16; i++) begin
      n_cmp++; if (pll_rst !== 1'b1) begin n_bad++; $display("FAIL pll_rst_pulse cycle %0d got %b want 1", i, pll_rst); end
      step(1);
    end
    n_cmp++; if (pll_rst !== 1'b0) begin n_bad++; $display("FAIL pll_rst_end got %b want 0", pll_rst); end
    goto_edge(39);
    locked = 1'b1;
    goto_edge(1069);
    n_cmp++; if (sys_reset !== 1'b1) begin n_bad++; $display("FAIL release_early got %b want 1", sys_reset); end
    goto_edge(1070);
    n_cmp++; if (sys_reset !== 1'b0) begin n_bad++; $display("FAIL release_1030 got %b want 0", sys_reset); end
    n_cmp++; if (fault !== 1'b0)     begin n_bad++; $display("FAIL run_fault got %b want 0", fault); end
    n_cmp++; if (retries !== 2'd0)   begin n_bad++; $display("FAIL run_retries got %0d want 0", retries); end
    n_cmp++; if (pll_rst !== 1'b0)   begin n_bad++; $display("FAIL run_pll_rst got %b want 0", pll_rst); end
  endtask

  task automatic test_glitch;
    step(5);
    locked = 1'b0;
    step(3);
    locked = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step(1);
      n_cmp++; if (lock_lost !== 1'b0) begin n_bad++; $display("FAIL glitch_lock_lost step %0d got %b want 0", i, lock_lost); end
      n_cmp++; if (sys_reset !== 1'b0) begin n_bad++; $display("FAIL glitch_sys_reset step %0d got %b want 0", i, sys_reset); end
    end
  endtask

  task automatic test_lock_loss;
    int e;
    e = pos + 1;
    locked = 1'b0;
    goto_edge(e + 5);
    n_cmp++; if (sys_reset !== 1'b0) begin n_bad++; $display("FAIL loss_early_sys_reset got %b want 0", sys_reset); end
    n_cmp++; if (lock_lost !== 1'b0) begin n_bad++; $display("FAIL loss_early_lock_lost got %b want 0", lock_lost); end
    goto_edge(e + 6);
    n_cmp++; if (sys_reset !== 1'b1) begin n_bad++; $display("FAIL loss_sys_reset got %b want 1", sys_reset); end
    n_cmp++; if (lock_lost !== 1'b1) begin n_bad++; $display("FAIL loss_pulse got %b want 1", lock_lost); end
    n_cmp++; if (pll_rst !== AR)     begin n_bad++; $display("FAIL loss_pll_rst got %b want %b", pll_rst, AR); end
    n_cmp++; if (fault !== !AR)      begin n_bad++; $display("FAIL loss_fault got %b want %b", fault, !AR); end
    n_cmp++; if (retries !== (AR ? 2'd1 : 2'd0)) begin n_bad++; $display("FAIL loss_retries got %0d want %0d", retries, AR ? 1 : 0); end
    goto_edge(e + 7);
    n_cmp++; if (lock_lost !== 1'b0) begin n_bad++; $display("FAIL loss_single_pulse got %b want 0", lock_lost); end
    goto_edge(e + 21);
    n_cmp++; if (pll_rst !== AR)     begin n_bad++; $display("FAIL loss_pll_rst_hold got %b want %b", pll_rst, AR); end
    goto_edge(e + 22);
    n_cmp++; if (pll_rst !== 1'b0)   begin n_bad++; $display("FAIL loss_pll_rst_end got %b want 0", pll_rst); end
    n_cmp++; if (sys_reset !== 1'b1) begin n_bad++; $display("FAIL loss_sys_reset_hold got %b want 1", sys_reset); end
  endtask

  task automatic test_stabilize_drop;
    release_reset(1'b0);
    goto_edge(39);
    locked = 1'b1;
    goto_edge(546);
    locked = 1'b0;
    goto_edge(556);
    locked = 1'b1;
    goto_edge(1070);
    n_cmp++; if (sys_reset !== 1'b1) begin n_bad++; $display("FAIL stab_no_early_release got %b want 1", sys_reset); end
    goto_edge(1586);
    n_cmp++; if (sys_reset !== 1'b1) begin n_bad++; $display("FAIL stab_release_early got %b want 1", sys_reset); end
    goto_edge(1587);
    n_cmp++; if (sys_reset !== 1'b0) begin n_bad++; $display("FAIL stab_release got %b want 0", sys_reset); end
    n_cmp++; if (fault !== 1'b0)     begin n_bad++; $display("FAIL stab_fault got %b want 0", fault); end
  endtask

  task automatic test_timeout;
    int nev;
    int ev;
    logic [1:0] exp_r;
    nev = AR ? 4 : 1;
    release_reset(1'b0);
    ev = 0;
    for (int n = 0; n < nev; n++) begin
      ev = 2015 + 2016 * n;
      goto_edge(ev - 1);
      n_cmp++; if (lock_lost !== 1'b0) begin n_bad++; $display("FAIL to_early_%0d got %b want 0", n, lock_lost); end
      goto_edge(ev);
      exp_r = AR ? ((n < 3) ? 2'(n + 1) : 2'd3) : 2'd0;
      n_cmp++; if (lock_lost !== 1'b1) begin n_bad++; $display("FAIL to_pulse_%0d got %b want 1", n, lock_lost); end
      n_cmp++; if (retries !== exp_r)  begin n_bad++; $display("FAIL to_retries_%0d got %0d want %0d", n, retries, exp_r); end
      n_cmp++; if (fault !== (n == nev - 1)) begin n_bad++; $display("FAIL to_fault_%0d got %b want %b", n, fault, n == nev - 1); end
      n_cmp++; if (pll_rst !== (n != nev - 1)) begin n_bad++; $display("FAIL to_pll_rst_%0d got %b want %b", n, pll_rst, n != nev - 1); end
    end
    goto_edge(ev + 50);
    n_cmp++; if (fault !== 1'b1)     begin n_bad++; $display("FAIL fault_sticky got %b want 1", fault); end
    n_cmp++; if (pll_rst !== 1'b0)   begin n_bad++; $display("FAIL fault_pll_rst got %b want 0", pll_rst); end
    n_cmp++; if (sys_reset !== 1'b1) begin n_bad++; $display("FAIL fault_sys_reset got %b want 1", sys_reset); end
    n_cmp++; if (lock_lost !== 1'b0) begin n_bad++; $display("FAIL fault_lock_lost got %b want 0", lock_lost); end
  endtask

  task automatic test_fault_reset;
    reset = 1'b1;
    step(1);
    n_cmp++; if (fault !== 1'b0)     begin n_bad++; $display("FAIL frst_fault got %b want 0", fault); end
    n_cmp++; if (retries !== 2'd0)   begin n_bad++; $display("FAIL frst_retries got %0d want 0", retries); end
    n_cmp++; if (pll_rst !== 1'b1)   begin n_bad++; $display("FAIL frst_pll_rst got %b want 1", pll_rst); end
    n_cmp++; if (sys_reset !== 1'b1) begin n_bad++; $display("FAIL frst_sys_reset got %b want 1", sys_reset); end
    reset = 1'b0;
    step(2);
  endtask

  initial begin
    n_cmp  = 0;
    n_bad  = 0;
    pos    = 0;
    reset  = 1'b1;
    locked = 1'b0;
    test_reset();
    test_glitch();
    test_lock_loss();
    test_stabilize_drop();
    test_timeout();
    test_fault_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
